// File: rtl/sliding_window_array_pkg.sv
// rtl/sliding_window_array_pkg.sv - shared state encoding, legal config constants and default sizes
package sliding_window_array_pkg;

  // Network-wide default sizes
  localparam int DEF_TN            = 8;
  localparam int DEF_FEATURE_WIDTH = 16;
  localparam int DEF_KERNEL_SIZE   = 5;

  localparam logic [1:0] STRIDE_1 = 2'd1;
  localparam logic [1:0] STRIDE_2 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Kernel must be odd (so non-zero) and fit the array; the row must be at least one kernel wide.
  function automatic logic cfg_legal(input logic [2:0] k, input logic [1:0] s,
                                     input logic [7:0] w, input int kmax);
    return k[0] && (int'(k) <= kmax) && (s == STRIDE_1 || s == STRIDE_2) && (w >= {5'd0, k});
  endfunction

endpackage

// File: rtl/sliding_window_array_window_shift_reg.sv
// rtl/sliding_window_array_window_shift_reg.sv - one channel K x K window shift register
// Ports: clk, rst (sync, active high), clear (empty the window), shift (accept col_in),
//        k (runtime kernel size), col_in (row r at r*FW), window (element (r,c) at (r*K+c)*FW).
module window_shift_reg #(
  parameter int KERNEL_SIZE   = 5,
  parameter int FEATURE_WIDTH = 16
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        clear,
  input  logic                                        shift,
  input  logic [2:0]                                  k,
  input  logic [KERNEL_SIZE*FEATURE_WIDTH-1:0]             col_in,
  output logic [KERNEL_SIZE*KERNEL_SIZE*FEATURE_WIDTH-1:0] window
);

  localparam int K  = KERNEL_SIZE;
  localparam int FW = FEATURE_WIDTH;

  // Each row is packed with column 0 (oldest) in the low bits, so a shift toward c=0 is a right shift.
  logic [K*FW-1:0] row_q   [K];
  logic [K*FW-1:0] row_nxt [K];

  always_comb begin
    for (int r = 0; r < K; r++) begin
      row_nxt[r] = row_q[r] >> FW;
      for (int c = 0; c < K; c++) begin
        if (c >= int'(k)) begin
          row_nxt[r][c*FW +: FW] = '0;
        end else if (c == int'(k) - 1) begin
          row_nxt[r][c*FW +: FW] = col_in[r*FW +: FW];
        end
      end
      if (r >= int'(k)) begin
        row_nxt[r] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int r = 0; r < K; r++) begin
      if (rst || clear) begin
        row_q[r] <= '0;
      end else if (shift) begin
        row_q[r] <= row_nxt[r];
      end
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_row
    assign window[r*K*FW +: K*FW] = row_q[r];
  end

endmodule

// File: rtl/sliding_window_array.sv
// rtl/sliding_window_array.sv - TN-channel sliding window generator over one feature row
// Ports: clk, rst (sync, active high); start + cfg_kernel_size/cfg_stride/cfg_feature_size;
//        in_select, in_data_0/1, in_valid/in_ready (column input);
//        out_window, out_valid/out_ready, out_last (window output); busy, done, cfg_err (status).
module sliding_window_array
  import sliding_window_array_pkg::*;
#(
  parameter int TN            = DEF_TN,
  parameter int FEATURE_WIDTH = DEF_FEATURE_WIDTH,
  parameter int KERNEL_SIZE   = DEF_KERNEL_SIZE
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic                                           start,
  input  logic [2:0]                                     cfg_kernel_size,
  input  logic [1:0]                                     cfg_stride,
  input  logic [7:0]                                     cfg_feature_size,
  input  logic                                           in_select,
  input  logic [TN*KERNEL_SIZE*FEATURE_WIDTH-1:0]             in_data_0,
  input  logic [TN*KERNEL_SIZE*FEATURE_WIDTH-1:0]             in_data_1,
  input  logic                                           in_valid,
  output logic                                           in_ready,
  output logic [TN*KERNEL_SIZE*KERNEL_SIZE*FEATURE_WIDTH-1:0] out_window,
  output logic                                           out_valid,
  input  logic                                           out_ready,
  output logic                                           out_last,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           cfg_err
);

  localparam int K  = KERNEL_SIZE;
  localparam int FW = FEATURE_WIDTH;

  state_t     state, state_nxt;
  logic [2:0] cfg_k;
  logic [1:0] cfg_s;
  logic [7:0] cfg_w;
  logic [7:0] col_cnt;
  logic [7:0] win_ofs;
  logic       start_idle, start_ok, accept, emit, emit_last, phase_ok;
  logic [TN*K*FW-1:0] in_col;

  assign start_idle = start && (state == ST_IDLE);
  assign start_ok   = start_idle && cfg_legal(cfg_kernel_size, cfg_stride, cfg_feature_size, K);
  assign in_ready   = (state == ST_RUN) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign in_col     = in_select ? in_data_1 : in_data_0;
  assign busy       = (state != ST_IDLE);

  // col_cnt is the index of the column being accepted; a window closes on it when
  // it is at least k-1 and lies on the stride grid counted from the first full window.
  assign win_ofs   = col_cnt - {5'd0, cfg_k} + 8'd1;
  assign phase_ok  = (cfg_s == STRIDE_1) || !win_ofs[0];
  assign emit      = (({1'b0, col_cnt} + 9'd1) >= {6'd0, cfg_k}) && phase_ok;
  assign emit_last = emit && (({1'b0, col_cnt} + {7'd0, cfg_s}) >= {1'b0, cfg_w});

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start_ok) state_nxt = ST_RUN;
      ST_RUN:   if (accept && (col_cnt == cfg_w - 8'd1)) state_nxt = ST_FLUSH;
      // The final column may not produce a window, so leave as soon as the output is drained.
      ST_FLUSH: if (!out_valid || out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cfg_k     <= '0;
      cfg_s     <= '0;
      cfg_w     <= '0;
      col_cnt   <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == ST_FLUSH) && (state_nxt == ST_IDLE);
      if (start_idle) begin
        cfg_err <= !start_ok;
      end
      if (start_ok) begin
        cfg_k   <= cfg_kernel_size;
        cfg_s   <= cfg_stride;
        cfg_w   <= cfg_feature_size;
        col_cnt <= '0;
      end else if (accept) begin
        col_cnt <= col_cnt + 8'd1;
      end
      if (accept && emit) begin
        out_valid <= 1'b1;
        out_last  <= emit_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < TN; i++) begin : g_chan
    window_shift_reg #(
      .KERNEL_SIZE  (K),
      .FEATURE_WIDTH(FW)
    ) u_win (
      .clk   (clk),
      .rst   (rst),
      .clear (start_ok),
      .shift (accept),
      .k     (cfg_k),
      .col_in(in_col[i*K*FW +: K*FW]),
      .window(out_window[i*K*K*FW +: K*K*FW])
    );
  end

endmodule

// File: tb/tb_sliding_window_array.sv
// tb/tb_sliding_window_array.sv - directed table-driven bench for sliding_window_array
module tb_sliding_window_array;

  localparam int TN = 8;
  localparam int FW = 16;
  localparam int K  = 5;
  localparam int IW = TN*K*FW;
  localparam int OW = TN*K*K*FW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    cfg_kernel_size = '0;
  logic [1:0]    cfg_stride = '0;
  logic [7:0]    cfg_feature_size = '0;
  logic          in_select = 1'b0;
  logic [IW-1:0] in_data_0 = '0;
  logic [IW-1:0] in_data_1 = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [OW-1:0] out_window;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          busy;
  logic          done;
  logic          cfg_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sliding_window_array #(.TN(TN), .FEATURE_WIDTH(FW), .KERNEL_SIZE(K)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_kernel_size(cfg_kernel_size),
    .cfg_stride(cfg_stride), .cfg_feature_size(cfg_feature_size), .in_select(in_select),
    .in_data_0(in_data_0), .in_data_1(in_data_1), .in_valid(in_valid), .in_ready(in_ready),
    .out_window(out_window), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  typedef struct {
    int k;
    int s;
    int w;
    int n_win;
    bit toggle;
    bit stall;
    int done_lat;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [FW-1:0] elem(input int i, input int r, input int col, input int src);
    return FW'(col + 16*r + 256*i + 4096*src);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_col(input int col, input bit sel);
    for (int i = 0; i < TN; i++) begin
      for (int r = 0; r < K; r++) begin
        in_data_0[(i*K+r)*FW +: FW] = elem(i, r, col, 0);
        in_data_1[(i*K+r)*FW +: FW] = elem(i, r, col, 1);
      end
    end
    in_select = sel;
  endtask

  task automatic check_window(input int n, input vec_t v, input int col);
    int bad_idx;
    logic [FW-1:0] a, e, bad_a, bad_e;
    bad_idx = -1;
    bad_a = '0;
    bad_e = '0;
    for (int i = 0; i < TN; i++) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          int cc;
          int src;
          cc  = n*v.s + c;
          src = v.toggle ? (cc % 2) : 0;
          e = (r < v.k && c < v.k) ? elem(i, r, cc, src) : '0;
          a = out_window[((i*K+r)*K+c)*FW +: FW];
          if (a !== e && bad_idx < 0) begin
            bad_idx = (i*K+r)*K+c;
            bad_a = a;
            bad_e = e;
          end
        end
      end
    end
    tests++;
    if (bad_idx >= 0) begin
      fails++;
      $display("FAIL window k=%0d s=%0d w=%0d n=%0d elem %0d: got %0h expected %0h",
               v.k, v.s, v.w, n, bad_idx, bad_a, bad_e);
    end
    chk("out_last", 32'(out_last), 32'(n == v.n_win - 1));
    chk("win_latency", col, n*v.s + v.k);
  endtask

  task automatic run_row(input vec_t v);
    int col, nwin, cyc, stall_left;
    bit stalled_once;
    logic [OW-1:0] held;
    col = 0; nwin = 0; cyc = 0; stall_left = 0; stalled_once = 0; held = '0;
    @(negedge clk);
    cfg_kernel_size  = 3'(v.k);
    cfg_stride       = 2'(v.s);
    cfg_feature_size = 8'(v.w);
    start = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("busy_after_start", 32'(busy), 1);
    chk("cfg_err_after_start", 32'(cfg_err), 0);
    @(negedge clk);
    while ((col < v.w || nwin < v.n_win) && cyc < 300) begin
      in_valid = (col < v.w);
      set_col(col, v.toggle ? col[0] : 1'b0);
      out_ready = (stall_left == 0);
      #1;
      if (v.stall && !stalled_once && out_valid) begin
        stalled_once = 1;
        stall_left = 5;
        held = out_window;
        out_ready = 1'b0;
        #1;
      end
      if (stall_left > 0) begin
        chk("stall_hold", 32'(!in_ready && out_valid && (out_window === held)), 1);
        stall_left--;
      end else if (out_valid) begin
        if (nwin >= v.n_win) begin
          chk("extra_window", nwin, v.n_win - 1);
        end else begin
          check_window(nwin, v, col);
        end
        nwin++;
      end
      if (in_valid && in_ready) col++;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("row_timeout", 32'(cyc < 300), 1);
    chk("window_count", nwin, v.n_win);
    for (int j = 0; j < v.done_lat; j++) @(negedge clk);
    #1;
    chk("done_pulse", 32'(done), 1);
    chk("idle_after_row", 32'(busy), 0);
    @(negedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 0);
  endtask

  task automatic cfg_err_case(input int k, input int s, input int w);
    logic seen_valid;
    seen_valid = 1'b0;
    @(negedge clk);
    cfg_kernel_size  = 3'(k);
    cfg_stride       = 2'(s);
    cfg_feature_size = 8'(w);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("cfg_err_set", 32'(cfg_err), 1);
    chk("cfg_err_busy", 32'(busy), 0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      #1;
      seen_valid = seen_valid | out_valid | in_ready;
    end
    in_valid = 1'b0;
    chk("cfg_err_no_output", 32'(seen_valid), 0);
    chk("cfg_err_sticky", 32'(cfg_err), 1);
  endtask

  initial begin
    //             k  s  w  n   toggle stall done_lat
    vecs[0] = '{3, 1, 8, 6, 1'b0, 1'b0, 0};
    vecs[1] = '{5, 2, 9, 3, 1'b0, 1'b0, 0};
    vecs[2] = '{1, 1, 4, 4, 1'b1, 1'b0, 0};
    vecs[3] = '{3, 2, 6, 2, 1'b0, 1'b0, 1};
    vecs[4] = '{3, 1, 6, 4, 1'b0, 1'b1, 0};
    vecs[5] = '{5, 1, 5, 1, 1'b0, 1'b0, 0};
    vecs[6] = '{3, 2, 7, 3, 1'b1, 1'b0, 0};

    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_in_ready", 32'(in_ready), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_cfg_err", 32'(cfg_err), 0);
    chk("reset_window", 32'(|out_window), 0);

    for (int v = 0; v < 7; v++) run_row(vecs[v]);

    cfg_err_case(4, 1, 9);
    cfg_err_case(3, 1, 2);
    cfg_err_case(3, 3, 8);
    cfg_err_case(0, 1, 8);

    // Reset in the middle of a row, after three columns have been accepted.
    @(negedge clk);
    cfg_kernel_size = 3'd3;
    cfg_stride = 2'd1;
    cfg_feature_size = 8'd8;
    start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      set_col(8 + j, 1'b0);
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_last", 32'(out_last), 0);
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_cfg_err", 32'(cfg_err), 0);
    chk("midrst_window", 32'(|out_window), 0);
    rst = 1'b0;
    run_row(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
